// File: rtl/drc_pkg.sv
// rtl/drc_pkg.sv - shared types and defaults for the DVP frame capture controller
package drc_pkg;

    // Default counter widths
    localparam int LINE_W_DEF = 11;
    localparam int FRM_W_DEF  = 10;
    localparam int CNT_W_DEF  = 16;

    // RGB565 pixel width and DVP byte width
    localparam int PIX_W  = 16;
    localparam int BYTE_W = 8;

    // Capture controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_SYNC   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

endpackage

// File: rtl/drc_byte_pack.sv
// rtl/drc_byte_pack.sv - pairs DVP bytes into RGB565 pixels and drives the FIFO write strobe
module drc_byte_pack
    import drc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,       // sampled byte with href=1 while capturing
    input  logic              clr,      // restart pairing (href edge or not capturing)
    input  logic [BYTE_W-1:0] d,
    input  logic              full,
    output logic              wr,
    output logic [PIX_W-1:0]  data,
    output logic              pix_evt,  // a pixel completes this cycle
    output logic              ovf_evt,  // that pixel is dropped because the FIFO is full
    output logic              partial   // high byte held, low byte not yet seen
);

    logic              phase;
    logic [BYTE_W-1:0] hi_byte;
    logic              eff_phase;

    // A clear in the same cycle as a byte makes that byte the high half
    assign eff_phase = clr ? 1'b0 : phase;
    assign pix_evt   = en & eff_phase;
    assign ovf_evt   = pix_evt & full;
    assign partial   = phase;

    // Byte pairing; the write strobe and pixel appear the cycle after the low byte
    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= 1'b0;
            hi_byte <= '0;
            wr      <= 1'b0;
            data    <= '0;
        end else begin
            wr <= 1'b0;
            if (en) begin
                if (!eff_phase) begin
                    hi_byte <= d;
                    phase   <= 1'b1;
                end else begin
                    phase <= 1'b0;
                    if (!full) begin
                        wr   <= 1'b1;
                        data <= {hi_byte, d};
                    end
                end
            end else if (clr) begin
                phase <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/drc_frame_ctrl.sv
// rtl/drc_frame_ctrl.sv - DVP frame capture FSM with line/frame size checking and error flags
module drc_frame_ctrl
    import drc_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int FRM_W  = FRM_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pclk_sync_i,
    input  logic              dvp_vsync_i,
    input  logic              dvp_href_i,
    input  logic [7:0]        dvp_d_i,
    input  logic              cfg_start_i,
    input  logic              cfg_stop_i,
    input  logic              cfg_clr_err_i,
    input  logic [LINE_W-1:0] cfg_ppl_i,
    input  logic [FRM_W-1:0]  cfg_lpf_i,
    input  logic              pfifo_full_i,
    output logic              pfifo_wr_o,
    output logic [15:0]       pfifo_data_o,
    output logic              frame_done_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic              err_ovf_o,
    output logic              err_size_o
);

    state_t            state;
    logic              stop_pend;
    logic              vsync_q;
    logic              href_q;
    logic [LINE_W-1:0] pix_cnt;
    logic [FRM_W-1:0]  line_cnt;
    logic [FRM_W-1:0]  line_cnt_nxt;

    logic active;
    logic vs_rise;
    logic href_rise;
    logic href_fall;
    logic frame_end;
    logic line_end;
    logic pack_en;
    logic pack_clr;
    logic pix_evt;
    logic ovf_evt;
    logic partial;
    logic line_mismatch;
    logic frame_mismatch;

    // Edge detection is only meaningful on PCLK strobes; the history registers hold otherwise
    assign active    = (state == ST_ACTIVE);
    assign vs_rise   = pclk_sync_i &  dvp_vsync_i & ~vsync_q;
    assign href_rise = pclk_sync_i &  dvp_href_i  & ~href_q;
    assign href_fall = pclk_sync_i & ~dvp_href_i  &  href_q;
    assign frame_end = active & vs_rise;
    assign line_end  = active & href_fall;
    assign pack_en   = active & pclk_sync_i & dvp_href_i;
    assign pack_clr  = ~active | href_rise | href_fall;

    // A line ending on the same strobe as the frame still counts before the frame check
    assign line_cnt_nxt = (line_end && !(&line_cnt)) ? line_cnt + FRM_W'(1) : line_cnt;

    assign line_mismatch  = line_end  & ((pix_cnt != cfg_ppl_i) | (&pix_cnt) | partial);
    assign frame_mismatch = frame_end & ((line_cnt_nxt != cfg_lpf_i) | (&line_cnt_nxt));

    drc_byte_pack u_pack (
        .clk     (clk),
        .rst     (rst),
        .en      (pack_en),
        .clr     (pack_clr),
        .d       (dvp_d_i),
        .full    (pfifo_full_i),
        .wr      (pfifo_wr_o),
        .data    (pfifo_data_o),
        .pix_evt (pix_evt),
        .ovf_evt (ovf_evt),
        .partial (partial)
    );

    // Previous sampled vsync/href, updated only on PCLK strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else if (pclk_sync_i) begin
            vsync_q <= dvp_vsync_i;
            href_q  <= dvp_href_i;
        end
    end

    // Capture FSM with registered busy, frame_done and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            stop_pend    <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            frame_cnt_o  <= '0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start_i && !cfg_stop_i) begin
                        state  <= ST_ARM;
                        busy_o <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (cfg_stop_i) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else if (pclk_sync_i && dvp_vsync_i) begin
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (cfg_stop_i) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end else if (pclk_sync_i && !dvp_vsync_i) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (frame_end) begin
                        frame_done_o <= 1'b1;
                        frame_cnt_o  <= frame_cnt_o + CNT_W'(1);
                        if (stop_pend || cfg_stop_i) begin
                            state     <= ST_IDLE;
                            busy_o    <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            state <= ST_SYNC;
                        end
                    end else if (cfg_stop_i) begin
                        stop_pend <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy_o    <= 1'b0;
                    stop_pend <= 1'b0;
                end
            endcase
        end
    end

    // Saturating pixel-per-line and line-per-frame counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (frame_end) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
        end else if (line_end) begin
            pix_cnt  <= '0;
            line_cnt <= line_cnt_nxt;
        end else if (pix_evt && !(&pix_cnt)) begin
            pix_cnt <= pix_cnt + LINE_W'(1);
        end
    end

    // Sticky error flags; a set in the same cycle wins over a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_o  <= 1'b0;
            err_size_o <= 1'b0;
        end else begin
            if (ovf_evt)
                err_ovf_o <= 1'b1;
            else if (cfg_clr_err_i)
                err_ovf_o <= 1'b0;

            if (line_mismatch || frame_mismatch)
                err_size_o <= 1'b1;
            else if (cfg_clr_err_i)
                err_size_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_drc_frame_ctrl.sv
// tb/tb_drc_frame_ctrl.sv - directed scoreboard bench for drc_frame_ctrl
module tb_drc_frame_ctrl;

    localparam int LINE_W = 11;
    localparam int FRM_W  = 10;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              pclk_sync;
    logic              dvp_vsync;
    logic              dvp_href;
    logic [7:0]        dvp_d;
    logic              cfg_start;
    logic              cfg_stop;
    logic              cfg_clr_err;
    logic [LINE_W-1:0] cfg_ppl;
    logic [FRM_W-1:0]  cfg_lpf;
    logic              pfifo_full;
    logic              pfifo_wr;
    logic [15:0]       pfifo_data;
    logic              frame_done;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;
    logic              err_ovf;
    logic              err_size;

    int          total = 0;
    int          bad = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic [15:0] first_wr = '0;
    bit          got_first = 1'b0;
    logic [7:0]  bval;
    int          w0;
    int          d0;

    always #5 clk = ~clk;

    drc_frame_ctrl #(.LINE_W(LINE_W), .FRM_W(FRM_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .pclk_sync_i   (pclk_sync),
        .dvp_vsync_i   (dvp_vsync),
        .dvp_href_i    (dvp_href),
        .dvp_d_i       (dvp_d),
        .cfg_start_i   (cfg_start),
        .cfg_stop_i    (cfg_stop),
        .cfg_clr_err_i (cfg_clr_err),
        .cfg_ppl_i     (cfg_ppl),
        .cfg_lpf_i     (cfg_lpf),
        .pfifo_full_i  (pfifo_full),
        .pfifo_wr_o    (pfifo_wr),
        .pfifo_data_o  (pfifo_data),
        .frame_done_o  (frame_done),
        .busy_o        (busy),
        .frame_cnt_o   (frame_cnt),
        .err_ovf_o     (err_ovf),
        .err_size_o    (err_size)
    );

    // Scoreboard consumer: every FIFO write must match the oldest expected pixel
    always @(negedge clk) begin
        if (pfifo_wr === 1'b1) begin
            wr_cnt++;
            if (!got_first) begin
                first_wr  = pfifo_data;
                got_first = 1'b1;
            end
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_write observed=%h expected=none", pfifo_data);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                total++;
                assert (pfifo_data === mon_exp) else begin
                    bad++;
                    $error("FAIL pixel_data observed=%h expected=%h", pfifo_data, mon_exp);
                end
            end
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One PCLK strobe followed by one idle clk
    task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
        dvp_vsync = vs;
        dvp_href  = hr;
        dvp_d     = d;
        pclk_sync = 1'b1;
        @(posedge clk); #1;
        pclk_sync = 1'b0;
        @(posedge clk); #1;
    endtask

    // n bytes with href high; full_pix selects a pixel that sees a full FIFO
    task automatic send_bytes(input int n, input int full_pix, input bit exp_wr);
        logic [7:0] hi;
        hi = '0;
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) begin
                hi = bval;
            end else begin
                pfifo_full = (i / 2 == full_pix);
                if (exp_wr && (i / 2 != full_pix)) exp_q.push_back({hi, bval});
            end
            tick(1'b0, 1'b1, bval);
            pfifo_full = 1'b0;
            bval = bval + 8'h22;
        end
    endtask

    task automatic send_line(input int n, input int full_pix, input bit exp_wr);
        send_bytes(n, full_pix, exp_wr);
        tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic pulse(input bit s, input bit p, input bit c);
        cfg_start   = s;
        cfg_stop    = p;
        cfg_clr_err = c;
        @(posedge clk); #1;
        cfg_start   = 1'b0;
        cfg_stop    = 1'b0;
        cfg_clr_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pclk_sync = 1'b0; dvp_vsync = 1'b0; dvp_href = 1'b0; dvp_d = '0;
        cfg_start = 1'b0; cfg_stop = 1'b0; cfg_clr_err = 1'b0;
        cfg_ppl = 11'd4; cfg_lpf = 10'd2; pfifo_full = 1'b0; bval = 8'h12;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr", pfifo_wr, 0);
        check("rst_data", pfifo_data, 0);
        check("rst_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_ovf", err_ovf, 0);
        check("rst_size", err_size, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame: 2 lines x 4 pixels
        pulse(1, 0, 0);
        check("busy_after_start", busy, 1);
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
        send_line(8, -1, 1);
        send_line(8, -1, 1);
        tick(1, 0, 0);
        check("f1_writes", wr_cnt, 8);
        check("f1_first_data", first_wr, 16'h1234);
        check("f1_done", done_cnt, 1);
        check("f1_cnt", frame_cnt, 1);
        check("f1_ovf", err_ovf, 0);
        check("f1_size", err_size, 0);

        // FIFO full on the third pixel of the first line
        tick(0, 0, 0);
        w0 = wr_cnt;
        send_line(8, 2, 1);
        check("ovf_line_writes", wr_cnt - w0, 3);
        check("ovf_flag", err_ovf, 1);
        check("ovf_size_clean", err_size, 0);
        send_line(8, -1, 1);
        tick(1, 0, 0);
        check("f2_cnt", frame_cnt, 2);
        check("f2_size", err_size, 0);
        pulse(0, 0, 1);
        check("ovf_cleared", err_ovf, 0);

        // Short line (3 pixels) raises size error, clear drops it next cycle
        tick(0, 0, 0);
        send_line(6, -1, 1);
        check("short_line_size", err_size, 1);
        pulse(0, 0, 1);
        check("short_line_cleared", err_size, 0);
        send_line(8, -1, 1);
        tick(1, 0, 0);
        check("f3_size", err_size, 0);
        check("f3_cnt", frame_cnt, 3);

        // Odd byte count: partial pixel discarded, size error
        tick(0, 0, 0);
        w0 = wr_cnt;
        send_line(9, -1, 1);
        check("odd_writes", wr_cnt - w0, 4);
        check("odd_size", err_size, 1);
        send_line(8, -1, 1);
        tick(1, 0, 0);
        pulse(0, 0, 1);
        check("odd_cleared", err_size, 0);

        // Frame-level line count mismatch
        tick(0, 0, 0);
        send_line(8, -1, 1);
        tick(1, 0, 0);
        check("lpf_mismatch", err_size, 1);
        check("f5_cnt", frame_cnt, 5);
        pulse(0, 0, 1);

        // Stop mid-ACTIVE: frame completes, then idle with no further writes
        tick(0, 0, 0);
        send_line(8, -1, 1);
        pulse(0, 1, 0);
        check("stop_busy_held", busy, 1);
        send_line(8, -1, 1);
        d0 = done_cnt;
        tick(1, 0, 0);
        check("stop_done", done_cnt - d0, 1);
        check("stop_busy_low", busy, 0);
        check("stop_cnt", frame_cnt, 6);
        w0 = wr_cnt;
        tick(0, 0, 0);
        send_line(8, -1, 0);
        send_line(8, -1, 0);
        tick(1, 0, 0);
        check("after_stop_writes", wr_cnt - w0, 0);
        check("after_stop_busy", busy, 0);

        // Start and stop together in IDLE stays idle
        pulse(1, 1, 0);
        check("start_stop_idle", busy, 0);

        // Reset mid-line
        pulse(1, 0, 0);
        tick(1, 0, 0); tick(0, 0, 0);
        send_bytes(5, -1, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_wr", pfifo_wr, 0);
        check("mid_rst_data", pfifo_data, 0);
        check("mid_rst_done", frame_done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", frame_cnt, 0);
        check("mid_rst_ovf", err_ovf, 0);
        check("mid_rst_size", err_size, 0);
        rst = 1'b0;

        // Start while vsync low mid-frame: nothing until a full vsync high->low
        pulse(1, 0, 0);
        w0 = wr_cnt;
        send_line(3, -1, 0);
        send_line(8, -1, 0);
        check("armed_no_writes", wr_cnt - w0, 0);
        check("armed_busy", busy, 1);
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
        bval = 8'h12;
        send_line(8, -1, 1);
        send_line(8, -1, 1);
        tick(1, 0, 0);
        check("restart_writes", wr_cnt - w0, 8);
        check("restart_cnt", frame_cnt, 1);
        check("restart_size", err_size, 0);
        check("restart_ovf", err_ovf, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
